// File: rtl/bidir_pkg.sv
// rtl/bidir_pkg.sv - shared state encoding and constants for bidirectional bus blocks
package bidir_pkg;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_TURN  = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    typedef enum logic [1:0] {
        S_LOAD  = ST_LOAD,
        S_TURN  = ST_TURN,
        S_DRIVE = ST_DRIVE
    } state_t;

    // Turnaround counter sizing; TURN parameters must stay within TURN_MAX.
    localparam int TCNT_W   = 4;
    localparam int TURN_MAX = 15;

    // Terminal value reached: all-ones when counting up, zero when counting down.
    function automatic logic at_terminal(input logic up, input logic all_ones, input logic zero);
        return up ? all_ones : zero;
    endfunction

endpackage

// File: rtl/bidir_io_cell.sv
// rtl/bidir_io_cell.sv - WIDTH-wide tri-state driver with input readback
module bidir_io_cell #(
    parameter int WIDTH = 5
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] dout,
    inout  wire  [WIDTH-1:0] bidir,
    output logic [WIDTH-1:0] din
);

    assign bidir = oe ? dout : {WIDTH{1'bz}};
    assign din   = bidir;

endmodule

// File: rtl/bidir_cnt_p.sv
// rtl/bidir_cnt_p.sv - parametrised up/down counter sharing a tri-state bus
module bidir_cnt_p
    import bidir_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int SAT   = 0,
    parameter int TURN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             ce,
    inout  wire  [WIDTH-1:0] bidir,
    output logic [WIDTH-1:0] q,
    output logic             drv,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  ZERO      = {WIDTH{1'b0}};
    localparam logic [TCNT_W-1:0] TURN_LAST = TCNT_W'((TURN > 0) ? TURN - 1 : 0);

    state_t            state, state_nxt;
    logic [TCNT_W-1:0] tcnt, tcnt_nxt;
    logic [WIDTH-1:0]  din;
    logic              step;

    bidir_io_cell #(.WIDTH(WIDTH)) u_io (
        .oe    (drv),
        .dout  (q),
        .bidir (bidir),
        .din   (din)
    );

    // Release is combinational so the bus frees up in the same cycle en falls.
    assign drv  = (state == S_DRIVE) & en & ~rst;
    assign tc   = (state == S_DRIVE) & at_terminal(up, q == ALL_ONES, q == ZERO);
    assign step = (state == S_DRIVE) & en & ce;

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        if (!en) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD: begin
                    if (TURN > 0) begin
                        state_nxt = S_TURN;
                        tcnt_nxt  = '0;
                    end else begin
                        state_nxt = S_DRIVE;
                    end
                end
                S_TURN: begin
                    if (tcnt == TURN_LAST) begin
                        state_nxt = S_DRIVE;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
                S_DRIVE: state_nxt = S_DRIVE;
                default: state_nxt = S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
            tcnt  <= '0;
            q     <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
            // A falling en always loads, even if a step was due on this edge.
            if (!en) begin
                q <= din;
            end else if (step) begin
                if (tc) begin
                    ovf <= 1'b1;
                end
                if (!(tc && SAT != 0)) begin
                    q <= up ? q + 1'b1 : q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bidir_cnt_p.sv
// tb/tb_bidir_cnt_p.sv - self-checking bench for bidir_cnt_p (wrap, saturate and long-turnaround instances)
module tb_bidir_cnt_p;

    localparam int MAXV = 31;

    logic       clk = 1'b0;
    logic       rst, en, up, ce;
    logic       xoe;
    logic [4:0] xval;

    wire  [4:0] bus0, bus1, bus2;
    logic [4:0] q0, q1, q2;
    logic       drv0, drv1, drv2, tc0, tc1, tc2, ovf0, ovf1, ovf2;

    assign bus0 = xoe ? xval : 5'bz;
    assign bus1 = xoe ? xval : 5'bz;
    assign bus2 = xoe ? xval : 5'bz;

    always #5 clk = ~clk;

    bidir_cnt_p #(.WIDTH(5), .SAT(0), .TURN(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .ce(ce), .bidir(bus0),
        .q(q0), .drv(drv0), .tc(tc0), .ovf(ovf0));
    bidir_cnt_p #(.WIDTH(5), .SAT(1), .TURN(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .ce(ce), .bidir(bus1),
        .q(q1), .drv(drv1), .tc(tc1), .ovf(ovf1));
    bidir_cnt_p #(.WIDTH(5), .SAT(0), .TURN(3)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .ce(ce), .bidir(bus2),
        .q(q2), .drv(drv2), .tc(tc2), .ovf(ovf2));

    int total = 0;
    int bad   = 0;

    // Reference model: q as an integer and the number of enabled edges since en last rose.
    int csat[3]  = '{0, 1, 0};
    int cturn[3] = '{1, 1, 3};
    int mq[3]    = '{0, 0, 0};
    int movf[3]  = '{0, 0, 0};
    int msince[3] = '{0, 0, 0};

    typedef struct {
        bit rst, en, up, ce, xoe;
        int xval;
        int q0, q1, ovf0, ovf1, drv0;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_drive_state(input int i);
        return msince[i] >= cturn[i] + 1;
    endfunction

    function automatic bit m_term(input int i);
        return up ? (mq[i] == MAXV) : (mq[i] == 0);
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mq[i] = 0; movf[i] = 0; msince[i] = 0;
            end else if (!en) begin
                mq[i] = int'(xval); msince[i] = 0;
            end else begin
                if (m_drive_state(i) && ce) begin
                    if (m_term(i)) begin
                        movf[i] = 1;
                        if (csat[i] == 0) mq[i] = up ? 0 : MAXV;
                    end else begin
                        mq[i] = up ? mq[i] + 1 : mq[i] - 1;
                    end
                end
                if (msince[i] < 100) msince[i]++;
            end
        end
    endtask

    task automatic check_all();
        int aq, adrv, atc, aovf, abus;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin aq = int'(q0); adrv = int'(drv0); atc = int'(tc0); aovf = int'(ovf0); abus = int'(bus0); end
                1: begin aq = int'(q1); adrv = int'(drv1); atc = int'(tc1); aovf = int'(ovf1); abus = int'(bus1); end
                default: begin aq = int'(q2); adrv = int'(drv2); atc = int'(tc2); aovf = int'(ovf2); abus = int'(bus2); end
            endcase
            chk($sformatf("model_q%0d", i), aq, mq[i]);
            chk($sformatf("model_ovf%0d", i), aovf, movf[i]);
            chk($sformatf("model_drv%0d", i), adrv, int'(en && !rst && m_drive_state(i)));
            chk($sformatf("model_tc%0d", i), atc, int'(m_drive_state(i) && m_term(i)));
            if (en && !rst && m_drive_state(i))
                chk($sformatf("model_bus%0d", i), abus, mq[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; up = 1'b1; ce = 1'b1; xoe = 1'b0; xval = 5'd0;

        // Reset held with en=1, then count from zero.
        tick(); tick();
        chk("rst_q0", int'(q0), 0);
        chk("rst_drv0", int'(drv0), 0);
        chk("rst_tc0", int'(tc0), 0);
        chk("rst_ovf0", int'(ovf0), 0);
        rst = 1'b0;
        tick();
        chk("rel_edge1_drv0", int'(drv0), 0);
        tick();
        chk("rel_edge2_drv0", int'(drv0), 1);
        chk("rel_edge2_q0", int'(q0), 0);
        tick();
        chk("count1_q0", int'(q0), 1);
        chk("count1_bus0", int'(bus0), 1);
        tick();
        chk("count2_q0", int'(q0), 2);

        // Wrap versus saturate, upward from 30 then downward from 1.
        tbl[0]  = '{1, 0, 1, 0, 1, 0,  0,  0,  0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 1, 30, 30, 30, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 1, 0, 0,  30, 30, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 1, 0, 0,  30, 30, 0, 0, 1};
        tbl[4]  = '{0, 1, 1, 1, 0, 0,  31, 31, 0, 0, 1};
        tbl[5]  = '{0, 1, 1, 1, 0, 0,  0,  31, 1, 1, 1};
        tbl[6]  = '{0, 1, 1, 1, 0, 0,  1,  31, 1, 1, 1};
        tbl[7]  = '{0, 0, 1, 1, 1, 1,  1,  1,  1, 1, 0};
        tbl[8]  = '{0, 1, 0, 1, 0, 0,  1,  1,  1, 1, 0};
        tbl[9]  = '{0, 1, 0, 1, 0, 0,  1,  1,  1, 1, 1};
        tbl[10] = '{0, 1, 0, 1, 0, 0,  0,  0,  1, 1, 1};
        tbl[11] = '{0, 1, 0, 1, 0, 0,  31, 0,  1, 1, 1};
        for (int r = 0; r < 12; r++) begin
            rst = tbl[r].rst; en = tbl[r].en; up = tbl[r].up; ce = tbl[r].ce;
            xoe = tbl[r].xoe; xval = 5'(tbl[r].xval);
            tick();
            chk($sformatf("tbl%0d_q0", r), int'(q0), tbl[r].q0);
            chk($sformatf("tbl%0d_q1", r), int'(q1), tbl[r].q1);
            chk($sformatf("tbl%0d_ovf0", r), int'(ovf0), tbl[r].ovf0);
            chk($sformatf("tbl%0d_ovf1", r), int'(ovf1), tbl[r].ovf1);
            chk($sformatf("tbl%0d_drv0", r), int'(drv0), tbl[r].drv0);
        end

        // Handover: en drops mid-drive while the agent drives 15.
        en = 1'b0; xoe = 1'b1; xval = 5'd9; up = 1'b1; ce = 1'b0;
        tick();
        en = 1'b1; xoe = 1'b0;
        tick(); tick();
        chk("ho_q0", int'(q0), 9);
        chk("ho_bus0", int'(bus0), 9);
        chk("ho_drv0", int'(drv0), 1);
        en = 1'b0; xoe = 1'b1; xval = 5'd15;
        #1;
        chk("ho_release_drv0", int'(drv0), 0);
        check_all();
        tick();
        chk("ho_load_q0", int'(q0), 15);

        // Long turnaround, then an en pulse during turnaround restarts it.
        en = 1'b1; xoe = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("turn3_edge%0d_drv2", k), int'(drv2), int'(k == 4));
        end
        en = 1'b0; xoe = 1'b1;
        tick();
        en = 1'b1; xoe = 1'b0;
        tick(); tick();
        chk("turn3_mid_drv2", int'(drv2), 0);
        en = 1'b0; xoe = 1'b1;
        tick();
        en = 1'b1; xoe = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("turn3_restart%0d_drv2", k), int'(drv2), int'(k == 4));
        end

        // Reset mid-drive clears count and sticky overflow.
        en = 1'b0; xoe = 1'b1; xval = 5'd12;
        tick();
        en = 1'b1; xoe = 1'b0;
        tick(); tick();
        chk("mdr_q0", int'(q0), 12);
        chk("mdr_ovf0_sticky", int'(ovf0), 1);
        rst = 1'b1;
        tick();
        chk("mdr_q0_cleared", int'(q0), 0);
        chk("mdr_ovf0_cleared", int'(ovf0), 0);
        chk("mdr_drv0", int'(drv0), 0);
        rst = 1'b0;

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            en   = ($urandom_range(0, 9) != 0);
            up   = 1'($urandom_range(0, 1));
            ce   = ($urandom_range(0, 4) != 0);
            xoe  = !en;
            xval = 5'($urandom_range(0, MAXV));
            if ($urandom_range(0, 7) == 0) xval = ($urandom_range(0, 1) != 0) ? 5'd31 : 5'd0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
